// File: rtl/writeback_unit.sv
// writeback_unit
//   Writeback stage of the microcoded RISC-V core. Takes completed ALU results
//   or load results, formats load data (byte/half/word, sign or zero extend),
//   and drives a one-cycle register-file write strobe. Stalls upstream (busy)
//   while a load is outstanding and exports the previous cycle's write so
//   consumers can bypass the register file's registered read.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   clk_enable          global enable; 0 freezes all state (reset still acts)
//   result_*            offered result (ALU data or load descriptor)
//   load_funct3/addr_low load type and byte offset, captured with the load
//   mem_rvalid/rdata    returning load data (raw aligned word)
//   busy                combinational stall, 1 while waiting for load data
//   reg_write_*         registered register-file write port
//   fwd_*               registered copy of the previous cycle's write
//
// state      | meaning
// S_IDLE     | accepting results; ALU results write next cycle
// S_WAIT_LOAD| load accepted, waiting for mem_rvalid; upstream stalled

module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        result_valid,
  input  logic        result_is_load,
  input  logic [4:0]  result_rd,
  input  logic [31:0] result_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_low,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  typedef enum logic {S_IDLE, S_WAIT_LOAD} state_t;

  state_t      state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fwd_valid_q, fwd_valid_d;
  logic [4:0]  fwd_rd_q, fwd_rd_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Load formatting uses the descriptor captured at acceptance, not the
  // live result_* inputs, which upstream may already have moved on.
  always_comb begin
    case (ld_addr_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = mem_rdata;  // LW and the unused encodings
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    fwd_valid_d = fwd_valid_q;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;

    if (clk_enable) begin
      // The strobe already excludes rd=0, so it doubles as the forward valid.
      fwd_valid_d = wen_q;
      fwd_rd_d    = waddr_q;
      fwd_data_d  = wdata_q;
      wen_d       = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (result_valid) begin
            if (result_is_load) begin
              ld_rd_d     = result_rd;
              ld_funct3_d = load_funct3;
              ld_addr_d   = load_addr_low;
              state_d     = S_WAIT_LOAD;
            end else begin
              wen_d   = (result_rd != 5'd0);
              waddr_d = result_rd;
              wdata_d = result_data;
            end
          end
        end
        S_WAIT_LOAD: begin
          if (mem_rvalid) begin
            wen_d   = (ld_rd_q != 5'd0);
            waddr_d = ld_rd_q;
            wdata_d = ld_value;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_rd_q     <= 5'd0;
      ld_funct3_q <= 3'd0;
      ld_addr_q   <= 2'd0;
      wen_q       <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign busy             = (state_q == S_WAIT_LOAD);
  assign reg_write_enable = wen_q;
  assign reg_write_addr   = waddr_q;
  assign reg_write_data   = wdata_q;
  assign fwd_valid        = fwd_valid_q;
  assign fwd_rd           = fwd_rd_q;
  assign fwd_data         = fwd_data_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the microcoded RISC-V core. It is the write-side counterpart of the register file. It accepts completed results from execute (ALU) or from the data-memory load path, and extracts, sign- or zero-extends and pulses each result onto the register-file write port. It stalls upstream while a load is outstanding. It also exports the previous cycle's write, so consumers can bypass the register file's one-cycle registered read.

## Interface
Parameters: none.

- clk  input  1  system clock; all state updates on posedge
- rst  input  1  reset; synchronous, active-high; acts regardless of clk_enable
- clk_enable  input  1  global clock enable; when 0, all state and outputs hold (except reset)
- result_valid  input  1  a result is offered this cycle
- result_is_load  input  1  offered result is a load; data arrives later on mem_rdata
- result_rd  input  5  destination register
- result_data  input  32  ALU result; ignored for loads
- load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- load_addr_low  input  2  byte offset of the load address
- mem_rvalid  input  1  load data valid this cycle
- mem_rdata  input  32  raw aligned memory word
- busy  output  1  combinational; 1 while in WAIT_LOAD; upstream must not advance
- reg_write_enable  output  1  register-file write strobe, registered
- reg_write_addr  output  5  registered write address
- reg_write_data  output  32  registered write data
- fwd_valid  output  1  registered; the previous cycle had a write to a nonzero rd
- fwd_rd  output  5  rd of that previous write
- fwd_data  output  32  data of that previous write

## Operation
- States: IDLE and WAIT_LOAD. All transitions require clk_enable=1.
- IDLE, result_valid=1, result_is_load=0:
  - next cycle: reg_write_enable=1, addr=result_rd, data=result_data
  - state stays IDLE
- IDLE, result_valid=1, result_is_load=1:
  - latch rd, funct3 and addr_low; go to WAIT_LOAD
  - no write that cycle
- WAIT_LOAD:
  - result_valid is ignored; upstream holds it, since busy=1
  - on mem_rvalid=1: format mem_rdata, then write next cycle and return to IDLE
  - otherwise: wait indefinitely (no timeout)
- mem_rvalid in IDLE is ignored.
- Load formatting:
  - LB/LBU: byte mem_rdata[8*addr_low +: 8]
  - LH/LHU: half mem_rdata[16*addr_low[1] +: 16]; addr_low[0] is ignored
  - LW: full word
  - LB/LH sign-extend; LBU/LHU zero-extend
  - funct3 values 011, 110 and 111 are treated as LW
- rd=0: reg_write_enable stays 0. addr and data still update, and fwd_valid=0.
- reg_write_enable is 1 for exactly one enabled cycle per accepted result.
- Forwarding:
  - at each enabled edge: fwd_valid <= reg_write_enable; fwd_rd <= reg_write_addr; fwd_data <= reg_write_data
  - reg_write_enable already implies rd≠0
- Write port outputs:
  - the write strobe drops to 0 on the enabled edge after the write
  - addr and data hold their last value until the next accepted result

## Timing
- Reset: state=IDLE, busy=0, reg_write_enable=0, reg_write_addr=0, reg_write_data=0, fwd_valid=0, fwd_rd=0, fwd_data=0.
- ALU result latency: 1 enabled cycle from acceptance to the write strobe.
- Load latency: 1 enabled cycle from the mem_rvalid edge to the write strobe. Total latency = memory latency + 1.
- busy rises the cycle after load acceptance.
- busy falls the cycle after mem_rvalid is sampled. A new result may be accepted in that same cycle, so back-to-back operation is allowed.
- Back-to-back ALU results produce a write strobe on every cycle.
- mem_rvalid in the same cycle as load acceptance is not sampled. Memory latency is at least 1.
- clk_enable=0 freezes everything, including strobes. A strobe spans exactly the enabled cycle after its cause, however long clk_enable stays low.
- Reset during WAIT_LOAD drops the pending load. A later mem_rvalid is then ignored.
- Reset in the cycle a strobe would rise suppresses that strobe.
- Reset with clk_enable=0 still resets.

## Test plan
- ALU write: result_rd=5, result_data=0xDEADBEEF, valid for 1 cycle -> next cycle reg_write_enable=1, addr=5, data=0xDEADBEEF. The cycle after -> fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF; reg_write_enable=0.
- LB sign-extend: funct3=000, addr_low=2, rd=7; mem_rvalid 3 cycles later with mem_rdata=0x12_80_34_56 -> busy=1 for 3 cycles, then a write to rd=7 of 0xFFFFFF80. A repeat with LBU writes 0x00000080.
- LH/LHU: addr_low=3 on mem_rdata=0x8001_1234. LH writes 0xFFFF8001; LHU writes 0x00008001. A repeat with addr_low=1 and LH writes 0x00001234.
- rd=0: an ALU result to rd=0 with data 0x55 -> reg_write_enable stays 0 and the fwd_valid cycle after stays 0.
- Hold and stall: result_valid held during WAIT_LOAD -> no write until mem_rvalid. The held ALU result is accepted the cycle busy falls and writes one cycle after the load's write.
- Reset and clk_enable:
  - rst during WAIT_LOAD, then mem_rvalid -> no write; all outputs 0
  - clk_enable low for 4 cycles mid-load -> mem_rvalid is ignored during that time, and the strobe occurs exactly one enabled cycle after the enabled mem_rvalid edge
